// File: rtl/alu_seq_ctrl.sv
// Multi-byte MADD/MXOR/MCMP sequencer driving an 8-bit ALU and a single-port sync-read memory.
// Optional feature macro: ALU_SEQ_SAT_EN (MADD overflow saturates the destination to 0xFF).

package alu_seq_pkg;

    // ALU opcode encodings shared with the ALU definitions
    localparam logic [4:0] OP_ADDACROSS = 5'h02;
    localparam logic [4:0] OP_XOR       = 5'h06;
    localparam logic [4:0] OP_BNE       = 5'h0D;

    typedef enum logic [1:0] {
        CMD_MADD = 2'b00,
        CMD_MXOR = 2'b01,
        CMD_MCMP = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_e;

endpackage

module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2,
    parameter int AW     = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,

    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [1:0]    req_cmd_i,
    input  logic [4:0]    req_len_i,
    input  logic [AW-1:0] req_srca_i,
    input  logic [AW-1:0] req_srcb_i,
    input  logic [AW-1:0] req_dst_i,

    output logic [AW-1:0] mem_addr_o,
    input  logic [7:0]    mem_rd_data_i,
    output logic          mem_wr_en_o,
    output logic [7:0]    mem_wr_data_o,

    output logic [4:0]    alu_op_o,
    output logic [7:0]    alu_a_o,
    output logic [7:0]    alu_imm_o,
    output logic          alu_sc_in_o,
    input  logic [7:0]    alu_out_i,
    input  logic          alu_sc_out_i,
    input  logic          alu_branch_i,

    output logic          done_o,
    output logic          done_carry_o,
    output logic          done_eq_o,
    output logic          done_err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
`ifdef ALU_SEQ_SAT_EN
        , S_SAT = 3'd5
`endif
    } state_e;

    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d;
    logic [4:0]    len_q, len_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [AW-1:0] srcb_q, srcb_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [4:0]    idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          eq_q, eq_d;
    logic          err_q, err_d;
    logic [7:0]    a_q, a_d;

    logic          req_legal;
    logic [4:0]    idx_inc;
    logic          last_byte;
    logic [AW-1:0] idx_ext;

    // Un-gated outputs; the reset gate is applied once at the port boundary
    logic          ready_raw;
    logic [AW-1:0] addr_raw;
    logic          wr_en_raw;
    logic [7:0]    wr_data_raw;
    logic [4:0]    alu_op_raw;
    logic [7:0]    alu_a_raw;
    logic [7:0]    alu_imm_raw;
    logic          sc_in_raw;
    logic          done_raw;

    assign req_legal = (req_cmd_i != CMD_ILL) && (req_len_i != 5'd0) &&
                       (req_len_i <= 5'(NBYTES));
    assign idx_inc   = idx_q + 5'd1;
    assign last_byte = (idx_inc == len_q);
    assign idx_ext   = AW'(idx_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the synchronous reset clears all control state in the same block.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_MADD;
            len_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            dst_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            dst_q   <= dst_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
            a_q     <= a_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        srca_d      = srca_q;
        srcb_d      = srcb_q;
        dst_d       = dst_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        eq_d        = eq_q;
        err_d       = err_q;
        a_d         = a_q;

        ready_raw   = 1'b0;
        addr_raw    = '0;
        wr_en_raw   = 1'b0;
        wr_data_raw = '0;
        alu_op_raw  = OP_XOR;
        alu_a_raw   = '0;
        alu_imm_raw = '0;
        sc_in_raw   = 1'b0;
        done_raw    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_raw = 1'b1;
                if (req_valid_i) begin
                    cmd_d   = cmd_e'(req_cmd_i);
                    len_d   = req_len_i;
                    srca_d  = req_srca_i;
                    srcb_d  = req_srcb_i;
                    dst_d   = req_dst_i;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    eq_d    = 1'b1;
                    err_d   = ~req_legal;
                    state_d = req_legal ? S_RDA : S_DONE;
                end
            end

            S_RDA: begin
                addr_raw = srca_q + idx_ext;
                state_d  = S_RDB;
            end

            // Operand A arrives now; operand B arrives in EXEC straight off the read port
            S_RDB: begin
                addr_raw = srcb_q + idx_ext;
                a_d      = mem_rd_data_i;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                alu_a_raw   = a_q;
                alu_imm_raw = mem_rd_data_i;
                addr_raw    = dst_q + idx_ext;
                idx_d       = idx_inc;
                case (cmd_q)
                    CMD_MADD: begin
                        alu_op_raw  = OP_ADDACROSS;
                        sc_in_raw   = carry_q;
                        wr_en_raw   = 1'b1;
                        wr_data_raw = alu_out_i;
                        carry_d     = alu_sc_out_i;
                    end
                    CMD_MXOR: begin
                        alu_op_raw  = OP_XOR;
                        wr_en_raw   = 1'b1;
                        wr_data_raw = alu_out_i;
                    end
                    CMD_MCMP: begin
                        alu_op_raw = OP_BNE;
                        eq_d       = eq_q & ~alu_branch_i;
                    end
                    default: ;
                endcase

                if (last_byte) begin
                    state_d = S_DONE;
`ifdef ALU_SEQ_SAT_EN
                    if ((cmd_q == CMD_MADD) && alu_sc_out_i) begin
                        state_d = S_SAT;
                        idx_d   = '0;
                    end
`endif
                end else begin
                    state_d = S_RDA;
                end
            end

`ifdef ALU_SEQ_SAT_EN
            // Overflowed sum: overwrite the whole destination with 0xFF, one byte per cycle
            S_SAT: begin
                addr_raw    = dst_q + idx_ext;
                wr_en_raw   = 1'b1;
                wr_data_raw = 8'hFF;
                idx_d       = idx_inc;
                if (last_byte) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                done_raw = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is asserted, including the write strobe
    assign req_ready_o   = ~reset_i & ready_raw;
    assign mem_addr_o    = reset_i ? '0 : addr_raw;
    assign mem_wr_en_o   = ~reset_i & wr_en_raw;
    assign mem_wr_data_o = reset_i ? '0 : wr_data_raw;
    assign alu_op_o      = reset_i ? '0 : alu_op_raw;
    assign alu_a_o       = reset_i ? '0 : alu_a_raw;
    assign alu_imm_o     = reset_i ? '0 : alu_imm_raw;
    assign alu_sc_in_o   = ~reset_i & sc_in_raw;
    assign done_o        = ~reset_i & done_raw;
    assign done_carry_o  = ~reset_i & done_raw & carry_q & (cmd_q == CMD_MADD) & ~err_q;
    assign done_eq_o     = ~reset_i & done_raw & eq_q & (cmd_q == CMD_MCMP) & ~err_q;
    assign done_err_o    = ~reset_i & done_raw & err_q;

endmodule
